// File: rtl/npc_controller_pkg.sv
// npc_controller_pkg: shared encodings and address defaults for the next-PC sequencer
package npc_controller_pkg;
  localparam logic [31:0] DEF_RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] DEF_EXC_VECTOR = 32'h0000_4180;
  typedef enum logic [2:0] {
    SRC_SEQ    = 3'd0,
    SRC_BRANCH = 3'd1,
    SRC_JUMP   = 3'd2,
    SRC_JR     = 3'd3,
    SRC_VEC    = 3'd4,
    SRC_ERET   = 3'd5
  } src_e;
  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_PEND    = 2'd1,
    ST_HANDLER = 2'd2
  } state_e;
endpackage

// File: rtl/npc_mux.sv
// npc_mux: priority select of the next fetch address and its source code
module npc_mux
  import npc_controller_pkg::*;
(
  input  logic        vec_sel,
  input  logic        eret_sel,
  input  logic        jr_valid,
  input  logic        jump_valid,
  input  logic        branch_taken,
  input  logic [31:0] vec_pc,
  input  logic [31:0] epc,
  input  logic [31:0] jr_target,
  input  logic [31:0] jump_target,
  input  logic [31:0] branch_target,
  input  logic [31:0] cur_pc,
  output logic [31:0] next_pc,
  output src_e        src
);
  // vector > eret > jr > jump > branch > sequential
  always_comb begin
    src     = vec_sel ? SRC_VEC : eret_sel ? SRC_ERET : jr_valid ? SRC_JR :
              jump_valid ? SRC_JUMP : branch_taken ? SRC_BRANCH : SRC_SEQ;
    next_pc = vec_sel ? vec_pc : eret_sel ? epc : jr_valid ? jr_target :
              jump_valid ? jump_target : branch_taken ? branch_target : cur_pc + 32'd4;
  end
endmodule

// File: rtl/npc_controller.sv
// npc_controller: next-PC selection, interrupt entry FSM, EPC and fetch PC mirror
module npc_controller
  import npc_controller_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
  parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
  input  logic        Clk,
  input  logic        Clr,
  input  logic        StallF,
  input  logic        CtrlInD,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  input  logic        JumpValid,
  input  logic [31:0] JumpTarget,
  input  logic        JrValid,
  input  logic [31:0] JrTarget,
  input  logic        EretValid,
  input  logic        IntReq,
  output logic [31:0] NextPC,
  output logic [2:0]  Source,
  output logic        IntTake,
  output logic        FlushFD,
  output logic [31:0] EpcOut,
  output logic        InHandler
);
  state_e      state, state_n;
  logic [31:0] cur_pc, epc, mux_pc;
  src_e        mux_src;
  logic        take, eret_go, blocked;
  npc_mux u_mux (
    .vec_sel      (take),
    .eret_sel     (eret_go),
    .jr_valid     (JrValid),
    .jump_valid   (JumpValid),
    .branch_taken (BranchTaken),
    .vec_pc       (EXC_VECTOR),
    .epc          (epc),
    .jr_target    (JrTarget),
    .jump_target  (JumpTarget),
    .branch_target(BranchTarget),
    .cur_pc       (cur_pc),
    .next_pc      (mux_pc),
    .src          (mux_src)
  );
  // take/eret decisions and next state; a stalled control transfer in D defers the take
  always_comb begin
    blocked = StallF & CtrlInD;
    take    = !Clr & !blocked & ((state == ST_RUN & IntReq) | state == ST_PEND);
    eret_go = !Clr & state == ST_HANDLER & EretValid & !StallF;
    state_n = state;
    if (take) state_n = ST_HANDLER;
    else if (state == ST_RUN & IntReq & blocked) state_n = ST_PEND;
    else if (eret_go) state_n = ST_RUN;
  end
  // state, fetch PC mirror and saved return address
  always_ff @(posedge Clk) begin
    if (Clr) begin
      state  <= ST_RUN;
      cur_pc <= RESET_PC;
      epc    <= '0;
    end else begin
      state <= state_n;
      if (!StallF | take) cur_pc <= mux_pc;
      if (take) epc <= CtrlInD ? cur_pc - 32'd4 : cur_pc;
    end
  end
  assign NextPC    = Clr ? RESET_PC : mux_pc;
  assign Source    = Clr ? SRC_SEQ : mux_src;
  assign IntTake   = take;
  assign FlushFD   = take | eret_go;
  assign EpcOut    = epc;
  assign InHandler = state == ST_HANDLER;
endmodule

// File: tb/tb_npc_controller.sv
// tb_npc_controller: scoreboard bench for the next-PC sequencer
module tb_npc_controller;
  logic        Clk = 0, Clr = 1, StallF = 0, CtrlInD = 0, BranchTaken = 0, JumpValid = 0;
  logic        JrValid = 0, EretValid = 0, IntReq = 0;
  logic [31:0] BranchTarget = 0, JumpTarget = 0, JrTarget = 0;
  logic [31:0] NextPC, EpcOut;
  logic [2:0]  Source;
  logic        IntTake, FlushFD, InHandler;
  int          passed = 0, total = 0;
  typedef struct packed {
    logic [31:0] npc;
    logic [2:0]  src;
    logic        take;
    logic        flush;
    logic [31:0] epc;
    logic        inh;
  } exp_t;
  exp_t  sb_q[$];
  string tag_q[$];
  npc_controller dut (
    .Clk(Clk), .Clr(Clr), .StallF(StallF), .CtrlInD(CtrlInD),
    .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
    .JumpValid(JumpValid), .JumpTarget(JumpTarget),
    .JrValid(JrValid), .JrTarget(JrTarget), .EretValid(EretValid), .IntReq(IntReq),
    .NextPC(NextPC), .Source(Source), .IntTake(IntTake), .FlushFD(FlushFD),
    .EpcOut(EpcOut), .InHandler(InHandler)
  );
  always #5 Clk = ~Clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs === exp) passed++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask
  task automatic cyc(input string tag, input logic clr, st, ci, bt, jv, jr, er, ir,
                     input logic [31:0] npc, input logic [2:0] src, input logic tk, fl,
                     input logic [31:0] epc, input logic inh);
    exp_t e;
    Clr = clr; StallF = st; CtrlInD = ci; BranchTaken = bt; JumpValid = jv;
    JrValid = jr; EretValid = er; IntReq = ir;
    sb_q.push_back('{npc, src, tk, fl, epc, inh});
    tag_q.push_back(tag);
    @(negedge Clk);
    e   = sb_q.pop_front();
    tag = tag_q.pop_front();
    chk({tag, ".npc"}, NextPC, e.npc);
    chk({tag, ".src"}, {29'd0, Source}, {29'd0, e.src});
    chk({tag, ".take"}, {31'd0, IntTake}, {31'd0, e.take});
    chk({tag, ".flush"}, {31'd0, FlushFD}, {31'd0, e.flush});
    chk({tag, ".epc"}, EpcOut, e.epc);
    chk({tag, ".inh"}, {31'd0, InHandler}, {31'd0, e.inh});
    @(posedge Clk);
    #1;
  endtask
  initial begin
    BranchTarget = 32'h3100; JumpTarget = 32'h3200; JrTarget = 32'h3300;
    repeat (2) @(posedge Clk);
    #1;
    //   tag          clr st ci bt jv jr er ir  npc           src tk fl epc           inh
    cyc("reset",       1, 0, 0, 0, 0, 0, 0, 0, 32'h3000,     0, 0, 0, 32'h0,       0);
    cyc("seq1",        0, 0, 0, 0, 0, 0, 0, 0, 32'h3004,     0, 0, 0, 32'h0,       0);
    cyc("seq2",        0, 0, 0, 0, 0, 0, 0, 0, 32'h3008,     0, 0, 0, 32'h0,       0);
    cyc("seq3",        0, 0, 0, 0, 0, 0, 0, 0, 32'h300C,     0, 0, 0, 32'h0,       0);
    cyc("clr_mid",     1, 0, 0, 0, 0, 0, 0, 0, 32'h3000,     0, 0, 0, 32'h0,       0);
    for (int i = 0; i < 4; i++)
      cyc("seq_rst",   0, 0, 0, 0, 0, 0, 0, 0, 32'h3004 + 32'(4 * i), 0, 0, 0, 32'h0, 0);
    cyc("branch",      0, 0, 1, 1, 0, 0, 0, 0, 32'h3100,     1, 0, 0, 32'h0,       0);
    cyc("br_land",     0, 0, 0, 0, 0, 0, 0, 0, 32'h3104,     0, 0, 0, 32'h0,       0);
    cyc("jr_over_j",   0, 0, 1, 0, 1, 1, 0, 0, 32'h3300,     3, 0, 0, 32'h0,       0);
    cyc("jump",        0, 0, 1, 0, 1, 0, 0, 0, 32'h3200,     2, 0, 0, 32'h0,       0);
    cyc("seq_3204",    0, 0, 0, 0, 0, 0, 0, 0, 32'h3204,     0, 0, 0, 32'h0,       0);
    cyc("take_ctrl",   0, 0, 1, 0, 0, 0, 0, 1, 32'h4180,     4, 1, 1, 32'h0,       0);
    cyc("hand_noest",  0, 0, 0, 0, 0, 0, 0, 1, 32'h4184,     0, 0, 0, 32'h3200,    1);
    cyc("eret1",       0, 0, 0, 0, 0, 0, 1, 0, 32'h3200,     5, 0, 1, 32'h3200,    1);
    cyc("post_eret",   0, 0, 0, 0, 0, 0, 0, 0, 32'h3204,     0, 0, 0, 32'h3200,    0);
    JumpTarget = 32'h3020;
    cyc("jump_3020",   0, 0, 1, 0, 1, 0, 0, 0, 32'h3020,     2, 0, 0, 32'h3200,    0);
    cyc("take_stall",  0, 1, 0, 0, 0, 0, 0, 1, 32'h4180,     4, 1, 1, 32'h3200,    0);
    cyc("hand_ireq",   0, 1, 0, 0, 0, 0, 0, 1, 32'h4184,     0, 0, 0, 32'h3020,    1);
    cyc("eret_wait",   0, 1, 0, 0, 0, 0, 1, 0, 32'h4184,     0, 0, 0, 32'h3020,    1);
    cyc("eret_go",     0, 0, 0, 0, 0, 0, 1, 0, 32'h3020,     5, 0, 1, 32'h3020,    1);
    cyc("run_eret",    0, 0, 0, 0, 0, 0, 1, 0, 32'h3024,     0, 0, 0, 32'h3020,    0);
    JumpTarget = 32'h3040;
    cyc("jump_3040",   0, 0, 1, 0, 1, 0, 0, 0, 32'h3040,     2, 0, 0, 32'h3020,    0);
    cyc("pend_enter",  0, 1, 1, 0, 0, 0, 0, 1, 32'h3044,     0, 0, 0, 32'h3020,    0);
    cyc("pend_hold",   0, 1, 1, 0, 0, 0, 0, 0, 32'h3044,     0, 0, 0, 32'h3020,    0);
    cyc("pend_take",   0, 0, 0, 0, 0, 0, 0, 0, 32'h4180,     4, 1, 1, 32'h3020,    0);
    cyc("pend_hand",   0, 0, 0, 0, 0, 0, 0, 0, 32'h4184,     0, 0, 0, 32'h3040,    1);
    cyc("clr_hand",    1, 0, 0, 0, 0, 0, 0, 1, 32'h3000,     0, 0, 0, 32'h3040,    1);
    cyc("post_clr",    0, 0, 0, 0, 0, 0, 0, 0, 32'h3004,     0, 0, 0, 32'h0,       0);
    cyc("take_vs_br",  0, 0, 1, 1, 0, 0, 0, 1, 32'h4180,     4, 1, 1, 32'h0,       0);
    cyc("no_back2back",0, 0, 0, 0, 0, 0, 0, 1, 32'h4184,     0, 0, 0, 32'h3000,    1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
